// File: rtl/peridot_board_infrom_if.sv
// Byte-read bus between the serial-ROM responder and the board-info image.
// The requester holds rd_req/rd_addr until it sees a one-cycle rd_ack.
interface peridot_board_infrom_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_ack;
    logic [7:0]            rd_data;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_ack,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_ack,
        output rd_data
    );
endinterface

// File: rtl/peridot_board_infrom.sv
// PERIDOT board-information ROM image: captures a UID (with startup delay and
// timeout fallback), sums the image into a checksum byte, then serves byte
// reads over a registered req/ack bus.
module peridot_board_infrom #(
    parameter int                     ADDR_WIDTH      = 6,
    parameter int                     UID_BYTES       = 8,
    parameter string                  UID_SOURCE      = "EXT",
    parameter logic [UID_BYTES*8-1:0] UID_VALUE       = '1,
    parameter logic [7:0]             PERIDOT_GENCODE = 8'h4e,
    parameter logic [7:0]             VERSION         = 8'h03,
    parameter int                     STARTUP_CYCLES  = 16,
    parameter int                     UID_TIMEOUT     = 1024
) (
    input  logic                     clock_sig,
    input  logic                     reset_sig,
    output logic                     ready,
    input  logic                     rescan,
    peridot_board_infrom_if.slave    rd_bus,
    input  logic [UID_BYTES*8-1:0]   ext_uid,
    input  logic                     ext_uid_valid,
    output logic                     uid_enable,
    output logic [UID_BYTES*8-1:0]   uid,
    output logic                     uid_valid,
    output logic                     uid_timeout
);
    localparam int          UW        = UID_BYTES * 8;
    localparam int          N         = 2 * UID_BYTES;
    localparam int          CS        = 10 + N;
    localparam bit          USE_EXT   = (UID_SOURCE == "EXT");
    localparam bit          TO_EN     = (UID_TIMEOUT != 0);
    localparam logic [31:0] WAIT_LAST = 32'(STARTUP_CYCLES - 1);
    localparam logic [31:0] TO_LAST   = 32'(UID_TIMEOUT - 1);
    localparam logic [31:0] CS_CNT    = 32'(CS);

    typedef enum logic [1:0] {S_WAIT, S_CAPTURE, S_SUM, S_READY} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] cnt;
    logic [7:0]  acc;
    logic [7:0]  csum;
    logic        wait_done;
    logic        take_src;
    logic        take_fallback;
    logic        sum_done;
    logic        serve;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // One byte of the image; the checksum slot returns the stored checksum.
    function automatic logic [7:0] image_byte(input logic [ADDR_WIDTH-1:0] addr,
                                              input logic [UW-1:0] u,
                                              input logic [7:0] cs);
        int         a;
        logic [3:0] nib;
        a = int'(addr);
        nib = 4'h0;
        image_byte = 8'hff;
        if (a < 10) begin
            case (a)
                0:       image_byte = 8'h4a;
                1:       image_byte = 8'h37;
                2:       image_byte = 8'h57;
                3:       image_byte = VERSION;
                4:       image_byte = 8'h4a;
                5:       image_byte = 8'h37;
                6:       image_byte = 8'h32;
                7:       image_byte = PERIDOT_GENCODE;
                8:       image_byte = 8'h39;
                default: image_byte = 8'h33;
            endcase
        end else if (a < CS) begin
            // Most significant nibble of the UID lands at address 10.
            nib = 4'(u >> (4 * (N - 1 - (a - 10))));
            image_byte = hex_ascii(nib);
        end else if (a == CS) begin
            image_byte = cs;
        end
    endfunction

    assign uid_enable = USE_EXT;

    // State register.
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) state <= S_WAIT;
        else            state <= state_next;
    end

    // Decoded per-state strobes that drive both the datapath and the next state.
    always_comb begin
        ready         = (state == S_READY);
        wait_done     = (state == S_WAIT) && (cnt == WAIT_LAST);
        take_src      = (wait_done && !USE_EXT) ||
                        ((state == S_CAPTURE) && (!USE_EXT || ext_uid_valid));
        take_fallback = (state == S_CAPTURE) && USE_EXT && !ext_uid_valid &&
                        TO_EN && (cnt == TO_LAST);
        sum_done      = (state == S_SUM) && (cnt == CS_CNT);
        serve         = ready && !rescan && rd_bus.rd_req && !rd_bus.rd_ack;
    end

    // Next-state logic; rescan only matters once a UID has been latched.
    always_comb begin
        state_next = state;
        case (state)
            S_WAIT:    if (wait_done) state_next = USE_EXT ? S_CAPTURE : S_SUM;
            S_CAPTURE: if (take_src || take_fallback) state_next = S_SUM;
            S_SUM: begin
                if (rescan)        state_next = S_CAPTURE;
                else if (sum_done) state_next = S_READY;
            end
            S_READY:   if (rescan) state_next = S_CAPTURE;
            default:   state_next = S_WAIT;
        endcase
    end

    // Shared startup/timeout/sum-index counter, cleared on every state change.
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig)                                  cnt <= '0;
        else if (state_next != state || state == S_READY) cnt <= '0;
        else                                            cnt <= cnt + 32'd1;
    end

    // UID latch; a source-valid in the timeout cycle takes priority.
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            uid         <= UID_VALUE;
            uid_valid   <= 1'b0;
            uid_timeout <= 1'b0;
        end else if (take_src) begin
            uid         <= USE_EXT ? ext_uid : UID_VALUE;
            uid_valid   <= 1'b1;
            uid_timeout <= 1'b0;
        end else if (take_fallback) begin
            uid         <= UID_VALUE;
            uid_valid   <= 1'b0;
            uid_timeout <= 1'b1;
        end
    end

    // Checksum accumulation: one image byte per cycle, then store the negation.
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            acc  <= 8'h00;
            csum <= 8'h00;
        end else if (take_src || take_fallback) begin
            acc <= 8'h00;
        end else if (state == S_SUM && cnt < CS_CNT) begin
            acc <= acc + image_byte(ADDR_WIDTH'(cnt), uid, csum);
        end else if (sum_done) begin
            csum <= 8'h00 - acc;
        end
    end

    // Registered read port; the ack gap makes a held request serve once.
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            rd_bus.rd_ack  <= 1'b0;
            rd_bus.rd_data <= 8'hff;
        end else begin
            rd_bus.rd_ack <= serve;
            if (serve) rd_bus.rd_data <= image_byte(rd_bus.rd_addr, uid, csum);
        end
    end
endmodule

// File: tb/tb_peridot_board_infrom.sv
// Self-checking bench for peridot_board_infrom: table vectors, timed
// sequences for capture/timeout/rescan/reset, and random reads against a
// behavioural image model.
module tb_peridot_board_infrom;
    localparam int AW = 6;

    logic        clock_sig = 1'b0;
    logic        reset_sig;
    logic        rescan, rescan_n;
    logic [63:0] ext_uid, ext_uid_n;
    logic        ext_uid_valid, ext_uid_valid_n;
    logic        ready, ready_n;
    logic        uid_enable, uid_enable_n;
    logic [63:0] uid, uid_n;
    logic        uid_valid, uid_valid_n;
    logic        uid_timeout, uid_timeout_n;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int         addr;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [10];

    always #5 clock_sig = ~clock_sig;

    peridot_board_infrom_if #(.ADDR_WIDTH(AW)) bus ();
    peridot_board_infrom_if #(.ADDR_WIDTH(AW)) bus_n ();

    peridot_board_infrom #(.ADDR_WIDTH(AW), .UID_TIMEOUT(1024)) dut (
        .clock_sig(clock_sig), .reset_sig(reset_sig), .ready(ready),
        .rescan(rescan), .rd_bus(bus), .ext_uid(ext_uid),
        .ext_uid_valid(ext_uid_valid), .uid_enable(uid_enable), .uid(uid),
        .uid_valid(uid_valid), .uid_timeout(uid_timeout)
    );

    peridot_board_infrom #(.ADDR_WIDTH(AW), .UID_SOURCE("NONE")) dut_n (
        .clock_sig(clock_sig), .reset_sig(reset_sig), .ready(ready_n),
        .rescan(rescan_n), .rd_bus(bus_n), .ext_uid(ext_uid_n),
        .ext_uid_valid(ext_uid_valid_n), .uid_enable(uid_enable_n), .uid(uid_n),
        .uid_valid(uid_valid_n), .uid_timeout(uid_timeout_n)
    );

    // Reference model: header text, hex-string UID, checksum as a plain sum.
    function automatic logic [7:0] body_byte(int a, logic [63:0] u);
        string      hexs = "0123456789ABCDEF";
        logic [7:0] hdr [10];
        int         idx;
        hdr = '{8'h4a, 8'h37, 8'h57, 8'h03, 8'h4a, 8'h37, 8'h32, 8'h4e, 8'h39, 8'h33};
        if (a < 10) return hdr[a];
        idx = int'((u >> (60 - 4 * (a - 10))) & 64'hf);
        return hexs.getc(idx);
    endfunction

    function automatic logic [7:0] ref_byte(int a, logic [63:0] u);
        int s;
        if (a < 26) return body_byte(a, u);
        if (a == 26) begin
            s = 0;
            for (int i = 0; i < 26; i++) s += body_byte(i, u);
            return 8'((256 - (s % 256)) % 256);
        end
        return 8'hff;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic do_read(input bit which, input int a, output logic [7:0] d, output bit ok);
        ok = 1'b0;
        d = 8'h00;
        if (which) begin bus_n.rd_req = 1'b1; bus_n.rd_addr = AW'(a); end
        else       begin bus.rd_req   = 1'b1; bus.rd_addr   = AW'(a); end
        for (int c = 0; c < 50; c++) begin
            @(negedge clock_sig);
            if (which ? bus_n.rd_ack : bus.rd_ack) begin
                d = which ? bus_n.rd_data : bus.rd_data;
                ok = 1'b1;
                break;
            end
        end
        if (which) bus_n.rd_req = 1'b0;
        else       bus.rd_req   = 1'b0;
    endtask

    task automatic rd_chk(input bit which, input int a, input logic [7:0] exp, input string name);
        logic [7:0] d;
        bit         ok;
        do_read(which, a, d, ok);
        if (!ok) begin
            checks++;
            $display("FAIL %s: got no rd_ack, expected ack within 50 cycles", name);
        end else begin
            chk(name, d, exp);
        end
    endtask

    task automatic wait_ready(input bit which, input int budget, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clock_sig);
            if (which ? ready_n : ready) begin
                cyc = c;
                break;
            end
        end
    endtask

    initial begin
        int         rdy_cyc, rdy_n_cyc, ack_cyc, cyc, a, s;
        logic [7:0] ack_data, d;
        logic [63:0] r;
        bit         ok;

        tbl[0] = '{0,  8'h4a};
        tbl[1] = '{2,  8'h57};
        tbl[2] = '{3,  8'h03};
        tbl[3] = '{7,  8'h4e};
        tbl[4] = '{9,  8'h33};
        tbl[5] = '{10, 8'h30};
        tbl[6] = '{19, 8'h39};
        tbl[7] = '{25, 8'h46};
        tbl[8] = '{26, 8'h16};
        tbl[9] = '{27, 8'hff};

        reset_sig = 1'b1;
        rescan = 1'b0;
        rescan_n = 1'b0;
        ext_uid = 64'h0123456789ABCDEF;
        ext_uid_valid = 1'b0;
        ext_uid_n = {$urandom, $urandom};
        ext_uid_valid_n = 1'b1;
        bus.rd_req = 1'b1;
        bus.rd_addr = '0;
        bus_n.rd_req = 1'b0;
        bus_n.rd_addr = '0;
        repeat (3) @(negedge clock_sig);

        chk("rst_ready", ready, 1'b0);
        chk("rst_rd_ack", bus.rd_ack, 1'b0);
        chk("rst_rd_data", bus.rd_data, 8'hff);
        chk("rst_uid", uid, 64'hffff_ffff_ffff_ffff);
        chk("rst_uid_valid", uid_valid, 1'b0);
        chk("rst_uid_timeout", uid_timeout, 1'b0);
        chk("uid_enable_ext", uid_enable, 1'b1);
        chk("uid_enable_none", uid_enable_n, 1'b0);

        // Capture at edge 40, read held from reset must stall until ready.
        reset_sig = 1'b0;
        rdy_cyc = -1; rdy_n_cyc = -1; ack_cyc = -1; ack_data = 8'h00;
        for (int c = 1; c <= 80; c++) begin
            ext_uid_valid = (c == 40);
            @(negedge clock_sig);
            if (ready && rdy_cyc < 0) rdy_cyc = c;
            if (ready_n && rdy_n_cyc < 0) rdy_n_cyc = c;
            if (bus.rd_ack && ack_cyc < 0) begin ack_cyc = c; ack_data = bus.rd_data; end
        end
        ext_uid_valid = 1'b0;
        bus.rd_req = 1'b0;
        @(negedge clock_sig);
        chk("ready_cycle_ext", 64'(rdy_cyc), 64'd67);
        chk("first_ack_cycle", 64'(ack_cyc), 64'd68);
        chk("first_ack_data", ack_data, 8'h4a);
        chk("ready_cycle_none", 64'(rdy_n_cyc), 64'd43);
        chk("uid_latched", uid, 64'h0123456789ABCDEF);
        chk("uid_valid_ext", uid_valid, 1'b1);
        chk("uid_timeout_ext", uid_timeout, 1'b0);

        for (int i = 0; i < 10; i++)
            rd_chk(1'b0, tbl[i].addr, tbl[i].exp, $sformatf("tbl_addr%0d", tbl[i].addr));
        for (int i = 0; i < 16; i++) begin
            a = $urandom_range(0, 63);
            rd_chk(1'b0, a, ref_byte(a, 64'h0123456789ABCDEF), $sformatf("rand_ext_addr%0d", a));
        end

        chk("none_uid", uid_n, 64'hffff_ffff_ffff_ffff);
        chk("none_uid_valid", uid_valid_n, 1'b1);
        rd_chk(1'b1, 26, 8'h58, "none_csum");
        for (int i = 0; i < 6; i++) begin
            a = $urandom_range(0, 63);
            rd_chk(1'b1, a, ref_byte(a, 64'hffff_ffff_ffff_ffff), $sformatf("rand_none_addr%0d", a));
        end

        // Rescan with a simultaneous read: rescan wins, old UID held until new latch.
        ext_uid = 64'hFEDCBA9876543210;
        rescan = 1'b1;
        bus.rd_req = 1'b1;
        bus.rd_addr = AW'(5);
        @(negedge clock_sig);
        rescan = 1'b0;
        bus.rd_req = 1'b0;
        chk("rescan_ready_drop", ready, 1'b0);
        chk("rescan_no_ack", bus.rd_ack, 1'b0);
        repeat (4) @(negedge clock_sig);
        chk("rescan_uid_held", uid, 64'h0123456789ABCDEF);
        ext_uid_valid = 1'b1;
        @(negedge clock_sig);
        ext_uid_valid = 1'b0;
        wait_ready(1'b0, 60, cyc);
        chk("rescan_ready_reached", 64'(cyc >= 0), 64'd1);
        rd_chk(1'b0, 10, 8'h46, "rescan_byte10");
        rd_chk(1'b0, 26, ref_byte(26, 64'hFEDCBA9876543210), "rescan_csum");
        s = 0;
        for (int i = 0; i <= 26; i++) begin
            do_read(1'b0, i, d, ok);
            s += int'(d);
        end
        chk("rescan_sum_zero", 64'(s % 256), 64'd0);

        // Timeout fallback: no valid ever arrives.
        reset_sig = 1'b1;
        @(negedge clock_sig);
        reset_sig = 1'b0;
        wait_ready(1'b0, 1200, cyc);
        chk("timeout_ready_reached", 64'(cyc >= 0), 64'd1);
        chk("timeout_flag", uid_timeout, 1'b1);
        chk("timeout_uid_valid", uid_valid, 1'b0);
        chk("timeout_uid", uid, 64'hffff_ffff_ffff_ffff);
        for (int i = 10; i < 26; i++) rd_chk(1'b0, i, 8'h46, $sformatf("timeout_byte%0d", i));
        rd_chk(1'b0, 26, 8'h58, "timeout_csum");

        // Asynchronous reset in the middle of the checksum pass.
        reset_sig = 1'b1;
        @(negedge clock_sig);
        reset_sig = 1'b0;
        r = {$urandom, $urandom};
        ext_uid = r;
        for (int c = 1; c <= 30; c++) begin
            ext_uid_valid = (c == 20);
            @(negedge clock_sig);
        end
        ext_uid_valid = 1'b0;
        chk("sum_uid_latched", uid, r);
        chk("sum_not_ready", ready, 1'b0);
        #2 reset_sig = 1'b1;
        #1;
        chk("midrst_ready", ready, 1'b0);
        chk("midrst_uid", uid, 64'hffff_ffff_ffff_ffff);
        chk("midrst_uid_valid", uid_valid, 1'b0);
        chk("midrst_rd_data", bus.rd_data, 8'hff);
        chk("midrst_rd_ack", bus.rd_ack, 1'b0);
        @(negedge clock_sig);
        reset_sig = 1'b0;
        rdy_cyc = -1;
        for (int c = 1; c <= 80; c++) begin
            ext_uid_valid = (c == 40);
            @(negedge clock_sig);
            if (ready && rdy_cyc < 0) rdy_cyc = c;
        end
        ext_uid_valid = 1'b0;
        chk("restart_ready_cycle", 64'(rdy_cyc), 64'd67);
        for (int i = 0; i < 8; i++) begin
            a = $urandom_range(0, 30);
            rd_chk(1'b0, a, ref_byte(a, r), $sformatf("restart_addr%0d", a));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/peridot_board_infrom.md
Name: peridot_board_infrom

Overview:
- Parametrised board-information serial-ROM image generator for the PERIDOT host bridge.
- Captures a UID from an external source (EPCQ/chip-ID front end) with startup delay and timeout fallback, and latches it.
- Computes an 8-bit checksum byte over the image, then serves byte reads through a registered req/ack handshake.
- Sits between the UID source and the host-bridge config/serial-ROM responder.

Parameters:
- ADDR_WIDTH, 6, byte address width; image space 2^ADDR_WIDTH bytes. Must satisfy 2^ADDR_WIDTH >= 11+2*UID_BYTES.
- UID_BYTES, 8, UID length in bytes (1..16).
- UID_SOURCE, "EXT", "EXT" = use ext_uid/ext_uid_valid; "NONE" = fixed UID_VALUE.
- UID_VALUE, all-ones (UID_BYTES*8 bits), fallback/fixed UID.
- PERIDOT_GENCODE, 8'h4e, generation code byte.
- VERSION, 8'h03, header version byte.
- STARTUP_CYCLES, 16, cycles after reset before capture starts (>=1).
- UID_TIMEOUT, 1024, capture timeout in cycles; 0 = wait forever.

Ports:
- clock_sig  in  1  clock; all logic posedge.
- reset_sig  in  1  asynchronous, active-high reset.
- ready  out  1  image valid, reads served.
- rescan  in  1  pulse: re-capture UID and recompute checksum.
- rd_req  in  1  level read request.
- rd_addr  in  ADDR_WIDTH  byte address, stable while rd_req=1.
- rd_ack  out  1  one-cycle pulse, rd_data valid.
- rd_data  out  8  read byte.
- ext_uid  in  UID_BYTES*8  external UID.
- ext_uid_valid  in  1  ext_uid valid.
- uid_enable  out  1  1 if UID_SOURCE="EXT".
- uid  out  UID_BYTES*8  latched UID.
- uid_valid  out  1  latched UID came from source.
- uid_timeout  out  1  capture timed out; fallback in use.

Behaviour:
- Reset values: ready=0, rd_ack=0, rd_data=8'hff, uid=UID_VALUE, uid_valid=0, uid_timeout=0, state=S_WAIT, counters=0. uid_enable is constant.
- Image layout, N=2*UID_BYTES, CS=10+N:
  - 0..9: 'J','7','W',VERSION,'J','7','2',PERIDOT_GENCODE,'9','3'.
  - 10..CS-1: uppercase ASCII hex of uid, MS nibble first.
  - CS: checksum = (256 - sum of bytes 0..CS-1) mod 256, so the 8-bit sum of bytes 0..CS is 0.
  - CS+1..top: 8'hff.
- S_WAIT: count STARTUP_CYCLES, then go to S_CAPTURE. If UID_SOURCE="NONE", instead latch UID_VALUE, set uid_valid=1, go to S_SUM.
- S_CAPTURE: timeout counter runs.
  - ext_uid_valid=1: latch ext_uid, uid_valid=1, uid_timeout=0, go to S_SUM.
  - Counter reaches UID_TIMEOUT (nonzero) with no valid: uid=UID_VALUE, uid_valid=0, uid_timeout=1, go to S_SUM.
  - Valid and timeout in the same cycle: valid wins.
- S_SUM: one image byte per cycle for addresses 0..CS-1 (CS cycles), 8-bit wrap accumulate. Then store the checksum, go to S_READY, ready=1 the following cycle.
- S_READY:
  - rd_req=1 and no rd_ack pending: register rd_data=image[rd_addr] and pulse rd_ack the next cycle.
  - Back-to-back requests get an ack every other cycle; the requester drops rd_req after the ack.
- Reads when not in S_READY stall with no ack; rd_req stays pending and is served once ready=1.
- rescan in S_READY or S_SUM: ready=0 next cycle, go to S_CAPTURE (timeout counter cleared). Previous uid is held until new latch. rescan in S_WAIT/S_CAPTURE is ignored.
- rescan together with rd_req in S_READY: rescan wins, no ack.
- reset_sig asserted in any state: immediate return to reset values; in-flight reads are dropped.

Test Plan:
- ext_uid=64'h0123456789ABCDEF, valid at cycle 40 -> ready=1 exactly CS+1=27 cycles after capture. Bytes 10..25="0123456789ABCDEF"; byte 26=8'h16; byte 27=8'hff; uid_valid=1.
- ext_uid_valid never asserted, UID_TIMEOUT=1024 -> uid_timeout=1, uid=all-ones, bytes 10..25 all 8'h46, byte 26=8'h58, uid_valid=0.
- rd_req held from reset with rd_addr=0 -> no rd_ack until ready; first ack one cycle after ready with rd_data=8'h4a.
- In READY, rescan pulse plus new ext_uid=64'hFEDCBA9876543210 -> ready drops next cycle; re-rises with byte 10='F'(8'h46) and checksum making the total sum 0.
- UID_SOURCE="NONE" -> uid_enable=0, uid_valid=1, ready after 16+26+1 cycles, ext inputs ignored.
- Reset asserted during S_SUM -> all outputs back to reset values the same cycle; full sequence restarts.
